// File: rtl/aes_job_arbiter_if.sv
// ----------------------------------------------------------------------------
// aes_job_arbiter_if : job/response handshake and AES core bus of the arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface aes_job_arbiter_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_mode;
  logic [255:0] req_data;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [127:0] resp_data;
  logic [127:0] core_data;
  logic         core_enc_en;
  logic         core_dec_en;
  logic [127:0] core_enc_out;
  logic [127:0] core_dec_out;
  logic         busy;
  logic         grant_id;

  // master: clients plus AES cores; slave: the arbiter itself
  modport master (
    output req_valid, req_mode, req_data, resp_ready, core_enc_out, core_dec_out,
    input  req_ready, resp_valid, resp_data, core_data, core_enc_en, core_dec_en,
           busy, grant_id
  );

  modport slave (
    input  req_valid, req_mode, req_data, resp_ready, core_enc_out, core_dec_out,
    output req_ready, resp_valid, resp_data, core_data, core_enc_en, core_dec_en,
           busy, grant_id
  );
endinterface

`default_nettype wire

// File: rtl/aes_job_arbiter.sv
// ----------------------------------------------------------------------------
// aes_job_arbiter : round-robin sharing of one AES encrypt and one decrypt core
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_job_arbiter #(
  parameter int NR = 10,
  parameter int CW = 5
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  aes_job_arbiter_if.slave bus
);

  generate
    if ((2 ** CW) <= (NR + 1)) begin : g_cw_check
      $error("CW too narrow for NR");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(NR);

  state_t        state;
  logic [CW-1:0] count;
  logic          mode;
  logic          last_grant;
  logic          grant_id_r;
  logic          busy_r;
  logic          enc_en;
  logic          dec_en;
  logic [1:0]    resp_valid_r;
  logic [127:0]  core_data_r;
  logic [127:0]  resp_data_r;

  logic          any_req;
  logic          gnt;
  logic          sel_mode;
  logic [127:0]  sel_data;
  logic          accept;

  // Tie goes to whoever did not win last; reset value of last_grant favours 0
  always_comb begin
    any_req  = |bus.req_valid;
    gnt      = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
    sel_mode = gnt ? bus.req_mode[1] : bus.req_mode[0];
    sel_data = gnt ? bus.req_data[255:128] : bus.req_data[127:0];
    accept   = rst_n && (state == IDLE) && any_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      mode         <= 1'b0;
      last_grant   <= 1'b1;
      grant_id_r   <= 1'b0;
      busy_r       <= 1'b0;
      enc_en       <= 1'b0;
      dec_en       <= 1'b0;
      resp_valid_r <= 2'b00;
      core_data_r  <= '0;
      resp_data_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            core_data_r <= sel_data;
            mode        <= sel_mode;
            grant_id_r  <= gnt;
            last_grant  <= gnt;
            enc_en      <= ~sel_mode;
            dec_en      <= sel_mode;
            busy_r      <= 1'b1;
            count       <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          count <= count + CW'(1);
          if (count == CNT_LAST) begin
            enc_en <= 1'b0;
            dec_en <= 1'b0;
            state  <= CAPT;
          end
        end
        CAPT: begin
          resp_data_r  <= mode ? bus.core_dec_out : bus.core_enc_out;
          resp_valid_r <= grant_id_r ? 2'b10 : 2'b01;
          count        <= '0;
          state        <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the handshake
          if (bus.resp_ready[grant_id_r]) begin
            resp_valid_r <= 2'b00;
            busy_r       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_data   = resp_data_r;
  assign bus.core_data   = core_data_r;
  assign bus.core_enc_en = enc_en;
  assign bus.core_dec_en = dec_en;
  assign bus.busy        = busy_r;
  assign bus.grant_id    = grant_id_r;

endmodule

`default_nettype wire

// File: tb/tb_aes_job_arbiter.sv
// ----------------------------------------------------------------------------
// tb_aes_job_arbiter : directed table-driven bench for aes_job_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_aes_job_arbiter;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_a5a5a5a5;
  localparam logic [127:0] XD   = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] YD   = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  aes_job_arbiter_if bus ();

  aes_job_arbiter #(.NR(10), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-in cores: the known FIPS-197 pair, anything else gets a fixed scramble
  assign bus.core_enc_out = (bus.core_data == PT) ? CT : (bus.core_data ^ MASK);
  assign bus.core_dec_out = (bus.core_data == CT) ? PT : ~bus.core_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   valid;
    logic [1:0]   mode;
    logic [255:0] data;
    logic         gid;
    logic [127:0] resp;
    int           hold;
    logic [1:0]   hold_rr;
    logic         pre;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int n;
    int lat;
    int enc_n;
    int dec_n;
    int viol;
    logic [1:0]   own;
    logic [127:0] cdata;
    logic [127:0] held;
    logic         m;
    own   = v.gid ? 2'b10 : 2'b01;
    cdata = v.gid ? v.data[255:128] : v.data[127:0];
    m     = v.gid ? v.mode[1] : v.mode[0];
    @(negedge clk);
    bus.req_valid  = v.valid;
    bus.req_mode   = v.mode;
    bus.req_data   = v.data;
    bus.resp_ready = v.pre ? own : 2'b00;
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check({v.name, " req_ready"}, 256'(bus.req_ready), 256'(own));
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    lat = 1; enc_n = 0; dec_n = 0; viol = 0;
    while (bus.resp_valid == 2'b00 && lat < 40) begin
      if (bus.core_enc_en) enc_n++;
      if (bus.core_dec_en) dec_n++;
      if (bus.req_ready != 2'b00 || !bus.busy || bus.core_data != cdata) viol++;
      @(posedge clk); #1; lat++;
    end
    check({v.name, " latency"}, 256'(lat), 256'(13));
    check({v.name, " enc_en cycles"}, 256'(enc_n), 256'(m ? 0 : 11));
    check({v.name, " dec_en cycles"}, 256'(dec_n), 256'(m ? 11 : 0));
    check({v.name, " run violations"}, 256'(viol), 256'(0));
    check({v.name, " grant_id"}, 256'(bus.grant_id), 256'(v.gid));
    check({v.name, " resp_valid"}, 256'(bus.resp_valid), 256'(own));
    check({v.name, " resp_data"}, 256'(bus.resp_data), 256'(v.resp));
    held = bus.resp_data;
    viol = 0;
    for (int i = 0; i < v.hold; i++) begin
      bus.resp_ready = v.hold_rr;
      bus.req_valid  = 2'b11;
      @(posedge clk); #1;
      if (bus.resp_valid != own || bus.resp_data != held || bus.req_ready != 2'b00) viol++;
    end
    check({v.name, " hold violations"}, 256'(viol), 256'(0));
    bus.req_valid  = 2'b00;
    bus.resp_ready = own;
    @(posedge clk); #1;
    check({v.name, " resp_valid drop"}, 256'(bus.resp_valid), 256'(0));
    check({v.name, " back to idle"}, 256'(bus.busy), 256'(0));
    bus.resp_ready = 2'b00;
  endtask

  initial begin
    int         n;
    int         grants;
    int         viol;
    logic [3:0] seq;

    tests = 0;
    fails = 0;
    vecs[0] = '{"T1 enc", 2'b01, 2'b00, {128'h0, PT}, 1'b0, CT, 0, 2'b00, 1'b0};
    vecs[1] = '{"T2 dec", 2'b10, 2'b10, {CT, 128'h0}, 1'b1, PT, 0, 2'b00, 1'b0};
    vecs[2] = '{"enc req1", 2'b10, 2'b00, {XD, 128'h0}, 1'b1, XD ^ MASK, 0, 2'b00, 1'b0};
    vecs[3] = '{"dec req0", 2'b01, 2'b01, {128'h0, YD}, 1'b0, ~YD, 0, 2'b00, 1'b0};
    vecs[4] = '{"T4 backpressure", 2'b01, 2'b00, {128'h0, PT}, 1'b0, CT, 20, 2'b00, 1'b0};
    vecs[5] = '{"T6 wrong owner", 2'b01, 2'b00, {128'h0, YD}, 1'b0, YD ^ MASK, 6, 2'b10, 1'b0};
    vecs[6] = '{"T4 same-cycle ready", 2'b10, 2'b10, {CT, 128'h0}, 1'b1, PT, 0, 2'b00, 1'b1};

    // Reset with both requesters already valid (T3 starts from here)
    rst_n          = 1'b0;
    bus.req_valid  = 2'b11;
    bus.req_mode   = 2'b10;
    bus.req_data   = {CT, PT};
    bus.resp_ready = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check("reset req_ready", 256'(bus.req_ready), 256'(0));
    check("reset resp_valid", 256'(bus.resp_valid), 256'(0));
    check("reset resp_data", 256'(bus.resp_data), 256'(0));
    check("reset core_data", 256'(bus.core_data), 256'(0));
    check("reset enables", 256'({bus.core_enc_en, bus.core_dec_en}), 256'(0));
    check("reset busy", 256'(bus.busy), 256'(0));
    check("reset grant_id", 256'(bus.grant_id), 256'(0));

    // T3: tie from reset, both resubmitting at once
    bus.resp_ready = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    grants = 0; viol = 0; n = 0; seq = 4'b0000;
    while (grants < 4 && n < 200) begin
      if (bus.req_ready != 2'b00 && bus.busy) viol++;
      if (bus.core_enc_en && bus.core_dec_en) viol++;
      if (bus.resp_valid == 2'b01) check("T3 resp0 data", 256'(bus.resp_data), 256'(CT));
      if (bus.resp_valid == 2'b10) check("T3 resp1 data", 256'(bus.resp_data), 256'(PT));
      if (bus.req_ready != 2'b00) begin
        seq[grants] = bus.req_ready[1];
        grants++;
      end
      if (grants < 4) begin
        @(negedge clk); #1; n++;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("T3 grant count", 256'(grants), 256'(4));
    check("T3 grant sequence", 256'(seq), 256'(4'b1010));
    check("T3 ready while busy", 256'(viol), 256'(0));
    check("T3 idle at end", 256'(bus.busy), 256'(0));
    bus.resp_ready = 2'b00;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // T5: reset at RUN count 5
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_mode  = 2'b00;
    bus.req_data  = {128'h0, PT};
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    check("T5 running before reset", 256'({bus.busy, bus.core_enc_en}), 256'(2'b11));
    rst_n = 1'b0;
    #1;
    check("T5 enables after reset", 256'({bus.core_enc_en, bus.core_dec_en}), 256'(0));
    check("T5 resp_valid after reset", 256'(bus.resp_valid), 256'(0));
    check("T5 busy after reset", 256'(bus.busy), 256'(0));
    check("T5 req_ready in reset", 256'(bus.req_ready), 256'(0));
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = 2'b00;
    run_job(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
